kbd_matrix_map: RTL

PS/2-to-key-matrix translator with a host-loadable keymap, parametrised matrix size and press-count tracking per matrix cell. It sits between the MiSTer `ps2_key` bus and the core's keyboard column scanner, and replaces hard-wired scan-code decoding. A key release always clears the cell its press set, even if shift changed while the key was held. Cells shared by several PS/2 keys stay pressed until every one of those keys is released.

---
 rtl/kbd_matrix_map_if.sv | 28 ++
 rtl/kbd_matrix_map.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_map_if.sv
// Keyboard matrix translator bus: PS/2 event input, keymap load port and
// scanner-facing matrix/modifier outputs.
interface kbd_matrix_map_if #(
    parameter int COLS = 16,
    parameter int ROWS = 4,
    parameter int CW   = $clog2(COLS)
);
    logic [10:0]     ps2_key;
    logic            all_up;
    logic            map_we;
    logic [9:0]      map_addr;
    logic [7:0]      map_data;
    logic [CW-1:0]   kb_col;
    logic [ROWS-1:0] kb_key;
    logic [3:0]      kb_mod;
    logic            status;
    logic            ovf;

    modport master (
        output ps2_key, all_up, map_we, map_addr, map_data, kb_col,
        input  kb_key, kb_mod, status, ovf
    );

    modport slave (
        input  ps2_key, all_up, map_we, map_addr, map_data, kb_col,
        output kb_key, kb_mod, status, ovf
    );
endinterface

// File: rtl/kbd_matrix_map.sv
// PS/2 to key-matrix translator: host-loaded keymap, per-cell press counters
// and a held table so releases always undo exactly what their press did.
module kbd_matrix_map #(
    parameter int COLS = 16,
    parameter int ROWS = 4
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    kbd_matrix_map_if.slave bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int IW    = $clog2(CELLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOOK  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    function automatic logic entry_ok(input logic [7:0] e);
        return e[7] && (int'(e[6:3]) < COLS) && (int'(e[2:0]) < ROWS);
    endfunction

    state_t          state_r, state_nx_s;
    logic            init_r, toggle_r;
    logic            event_s, is_mod_s, mod_evt_s, lookup_evt_s;
    logic [9:0]      ev_key_s, cap_key_r, pend_key_r;
    logic            pend_valid_r, idle_s, look_s, apply_s;
    logic            take_s, pend_store_s, pend_take_s, drop_s;
    logic [7:0]      keymap [1024];
    logic [6:0]      held_mem [512];
    logic [7:0]      map_q_r;
    logic [6:0]      held_q_r, cell_s;
    logic [511:0]    hvalid_r;
    logic [2:0]      cnt_r [CELLS];
    logic [IW-1:0]   cell_idx_s;
    logic            inc_s, dec_s, shift_s;
    logic            mod_evt_r, mod_press_r;
    logic [7:0]      mod_code_r;
    logic            shift_l_r, shift_r_r, ctrl_r;
    logic            shift_l_nx_s, shift_r_nx_s, ctrl_nx_s;
    logic [3:0]      kb_mod_r;
    logic [ROWS-1:0] kb_key_r, row_s;
    logic            status_r, ovf_r;

    // Modifiers bypass the lookup FSM and the pending register entirely.
    assign event_s      = init_r & (bus.ps2_key[10] ^ toggle_r);
    assign is_mod_s     = (bus.ps2_key[7:0] == 8'h12) || (bus.ps2_key[7:0] == 8'h59) ||
                          (bus.ps2_key[7:0] == 8'h14);
    assign mod_evt_s    = event_s & is_mod_s & ~bus.all_up;
    assign lookup_evt_s = event_s & ~is_mod_s & ~bus.all_up;
    assign ev_key_s     = bus.ps2_key[9:0];
    assign shift_s      = shift_l_r | shift_r_r;

    // The pending entry is always older than a new event, so it is served first.
    assign take_s       = idle_s & (pend_valid_r | lookup_evt_s);
    assign pend_take_s  = idle_s & pend_valid_r;
    assign pend_store_s = lookup_evt_s & (idle_s ? pend_valid_r : ~pend_valid_r);
    assign drop_s       = lookup_evt_s & ~idle_s & pend_valid_r;

    // Event detection: first cycle after reset only loads the toggle copy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init_r   <= 1'b0;
            toggle_r <= 1'b0;
        end else begin
            init_r   <= 1'b1;
            toggle_r <= bus.ps2_key[10];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; all_up always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        if (bus.all_up) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = take_s ? ST_LOOK : ST_IDLE;
                ST_LOOK:  state_nx_s = ST_APPLY;
                ST_APPLY: state_nx_s = ST_IDLE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        idle_s  = 1'b0;
        look_s  = 1'b0;
        apply_s = 1'b0;
        case (state_r)
            ST_IDLE:  idle_s  = 1'b1;
            ST_LOOK:  look_s  = 1'b1;
            ST_APPLY: apply_s = 1'b1;
            default:  idle_s  = 1'b1;
        endcase
    end

    // Event capture and one-deep pending register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cap_key_r    <= 10'd0;
            pend_key_r   <= 10'd0;
            pend_valid_r <= 1'b0;
        end else if (bus.all_up) begin
            pend_valid_r <= 1'b0;
        end else begin
            if (take_s) begin
                cap_key_r <= pend_valid_r ? pend_key_r : ev_key_s;
            end
            if (pend_store_s) begin
                pend_valid_r <= 1'b1;
                pend_key_r   <= ev_key_s;
            end else if (pend_take_s) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

    // Keymap and held-table RAMs; contents are host state and never reset.
    always_ff @(posedge clk_sys) begin
        if (bus.map_we) begin
            keymap[bus.map_addr] <= bus.map_data;
        end
        if (look_s) begin
            map_q_r  <= keymap[{shift_s, cap_key_r[8:0]}];
            held_q_r <= held_mem[cap_key_r[8:0]];
        end
        if (inc_s) begin
            held_mem[cap_key_r[8:0]] <= map_q_r[6:0];
        end
    end

    // Apply decision: a release uses the held cell, never the current keymap.
    always_comb begin
        inc_s      = apply_s & cap_key_r[9] & entry_ok(map_q_r) & ~hvalid_r[cap_key_r[8:0]];
        dec_s      = apply_s & ~cap_key_r[9] & hvalid_r[cap_key_r[8:0]];
        cell_s     = cap_key_r[9] ? map_q_r[6:0] : held_q_r;
        cell_idx_s = IW'(int'(cell_s[6:3]) * ROWS + int'(cell_s[2:0]));
    end

    // Held valid bits and saturating per-cell counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hvalid_r <= 512'd0;
            for (int i = 0; i < CELLS; i++) cnt_r[i] <= 3'd0;
        end else if (bus.all_up) begin
            hvalid_r <= 512'd0;
            for (int i = 0; i < CELLS; i++) cnt_r[i] <= 3'd0;
        end else begin
            if (inc_s) begin
                hvalid_r[cap_key_r[8:0]] <= 1'b1;
            end else if (dec_s) begin
                hvalid_r[cap_key_r[8:0]] <= 1'b0;
            end
            for (int i = 0; i < CELLS; i++) begin
                if (inc_s && (IW'(i) == cell_idx_s) && (cnt_r[i] != 3'd7)) begin
                    cnt_r[i] <= cnt_r[i] + 3'd1;
                end else if (dec_s && (IW'(i) == cell_idx_s) && (cnt_r[i] != 3'd0)) begin
                    cnt_r[i] <= cnt_r[i] - 3'd1;
                end
            end
        end
    end

    // Modifier event staging, applied one cycle after detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mod_evt_r   <= 1'b0;
            mod_press_r <= 1'b0;
            mod_code_r  <= 8'd0;
        end else begin
            mod_evt_r <= mod_evt_s;
            if (mod_evt_s) begin
                mod_press_r <= bus.ps2_key[9];
                mod_code_r  <= bus.ps2_key[7:0];
            end
        end
    end

    // Next modifier state.
    always_comb begin
        shift_l_nx_s = shift_l_r;
        shift_r_nx_s = shift_r_r;
        ctrl_nx_s    = ctrl_r;
        if (mod_evt_r) begin
            case (mod_code_r)
                8'h12:   shift_l_nx_s = mod_press_r;
                8'h59:   shift_r_nx_s = mod_press_r;
                8'h14:   ctrl_nx_s    = mod_press_r;
                default: ctrl_nx_s    = ctrl_r;
            endcase
        end else begin
            ctrl_nx_s = ctrl_r;
        end
    end

    // Modifier registers and kb_mod output.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shift_l_r <= 1'b0;
            shift_r_r <= 1'b0;
            ctrl_r    <= 1'b0;
            kb_mod_r  <= 4'b1111;
        end else if (bus.all_up) begin
            shift_l_r <= 1'b0;
            shift_r_r <= 1'b0;
            ctrl_r    <= 1'b0;
            kb_mod_r  <= 4'b1111;
        end else begin
            shift_l_r <= shift_l_nx_s;
            shift_r_r <= shift_r_nx_s;
            ctrl_r    <= ctrl_nx_s;
            kb_mod_r  <= {1'b1, 1'b1, ~(shift_l_nx_s | shift_r_nx_s), ~ctrl_nx_s};
        end
    end

    // Column lookup for the scanner; out-of-range columns read as released.
    always_comb begin
        row_s = {ROWS{1'b1}};
        if (int'(bus.kb_col) < COLS) begin
            for (int r = 0; r < ROWS; r++) begin
                row_s[r] = (cnt_r[IW'(int'(bus.kb_col) * ROWS + r)] == 3'd0);
            end
        end else begin
            row_s = {ROWS{1'b1}};
        end
    end

    // Registered matrix row, status and overflow outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            kb_key_r <= {ROWS{1'b1}};
            status_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (bus.all_up) begin
            kb_key_r <= {ROWS{1'b1}};
            ovf_r    <= 1'b0;
        end else begin
            kb_key_r <= row_s;
            ovf_r    <= drop_s;
            if (event_s && !drop_s) begin
                status_r <= bus.ps2_key[9];
            end
        end
    end

    assign bus.kb_key = kb_key_r;
    assign bus.kb_mod = kb_mod_r;
    assign bus.status = status_r;
    assign bus.ovf    = ovf_r;
endmodule
